// File: rtl/l2p_toggle_receiver.sv
// Destination end of a pulse-to-level toggle crossing: sync, edge detect, pending-event counter.
// Optional level echo for source-side flow control when L2P_TOGGLE_ACK_EN is defined.
module l2p_toggle_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             tgl_in,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf,
    output logic             ack_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_lvl;
    logic                   s_prev;
    logic                   edge_det;
    logic                   full;
    logic                   dec;
    logic                   ovf_set;
    logic [CNT_W-1:0]       cnt_nxt;

    // Plain flop chain; no logic between stages.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_in};
        end
    end

    assign s_lvl    = sync_q[SYNC_STAGES-1];
    assign edge_det = s_lvl ^ s_prev;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            s_prev    <= 1'b0;
            evt_pulse <= 1'b0;
        end else begin
            s_prev    <= s_lvl;
            evt_pulse <= edge_det;
        end
    end

    assign evt_valid = (pend_cnt != '0);
    assign full      = (pend_cnt == CNT_MAX);
    assign dec       = evt_valid && evt_ready;

    // A simultaneous arrival and acceptance cancel, even when saturated.
    always_comb begin
        cnt_nxt = pend_cnt;
        ovf_set = 1'b0;
        unique case (1'b1)
            evt_pulse && dec: cnt_nxt = pend_cnt;
            evt_pulse && !dec && !full: cnt_nxt = pend_cnt + CNT_ONE;
            evt_pulse && !dec && full: ovf_set = 1'b1;
            !evt_pulse && dec: cnt_nxt = pend_cnt - CNT_ONE;
            default: cnt_nxt = pend_cnt;
        endcase
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            pend_cnt <= '0;
        end else begin
            pend_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef L2P_TOGGLE_ACK_EN
    assign ack_out = s_prev;
`else
    assign ack_out = 1'b0;
`endif

endmodule

// File: tb/tb_l2p_toggle_receiver.sv
// Scoreboard bench for l2p_toggle_receiver: expected pulse cycles queued by stimulus,
// popped by a monitor on each evt_pulse; counter/flag checks inline.
module tb_l2p_toggle_receiver;

    localparam int SYNC  = 2;
    localparam int CW    = 4;
`ifdef L2P_TOGGLE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic          clk1 = 1'b0;
    logic          reset;
    logic          tgl_in;
    logic          evt_ready;
    logic          ovf_clr;
    logic          evt_pulse;
    logic          evt_valid;
    logic [CW-1:0] pend_cnt;
    logic          ovf;
    logic          ack_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];

    l2p_toggle_receiver #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk1      (clk1),
        .reset     (reset),
        .tgl_in    (tgl_in),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .pend_cnt  (pend_cnt),
        .ovf       (ovf),
        .ack_out   (ack_out)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed pulse must match the next queued cycle.
    always @(negedge clk1) begin
        if (!reset && evt_pulse) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pulse_unexpected: pulse at cyc %0d, none queued", cyc);
            end else begin
                chk("pulse_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk1);
    endtask

    // Called at a negedge: captured at the next edge, visible SYNC edges later.
    task automatic tog();
        tgl_in = ~tgl_in;
        exp_q.push_back(cyc + 1 + SYNC);
    endtask

    initial begin
        reset     = 1'b1;
        tgl_in    = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick(3);
        chk("rst_pulse", evt_pulse, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_cnt", pend_cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ack", ack_out, 0);
        reset = 1'b0;
        tick(5);

        // Single event with consumer ready
        evt_ready = 1'b1;
        tog();
        tick(3);
        chk("t1_ack_rise", ack_out, ACK ? 1 : 0);
        tick(1);
        chk("t1_cnt1", pend_cnt, 1);
        chk("t1_valid1", evt_valid, 1);
        tick(1);
        chk("t1_cnt0", pend_cnt, 0);
        chk("t1_valid0", evt_valid, 0);
        evt_ready = 1'b0;
        tick(3);

        // Five buffered events, then drain
        for (int i = 0; i < 5; i++) begin
            tog();
            tick(4);
        end
        chk("t2_cnt5", pend_cnt, 5);
        chk("t2_ovf0", ovf, 0);
        evt_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk("t2_drain_cnt", pend_cnt, 5 - i);
            chk("t2_drain_valid", evt_valid, (i < 5) ? 1 : 0);
        end
        evt_ready = 1'b0;
        tick(2);

        // Saturation
        for (int i = 0; i < 15; i++) begin
            tog();
            tick(4);
        end
        chk("t3_cnt15", pend_cnt, 15);
        chk("t3_ovf_pre", ovf, 0);
        tog();
        tick(4);
        chk("t3_cnt_sat", pend_cnt, 15);
        chk("t3_ovf_set", ovf, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", ovf, 0);
        chk("t3_cnt_keep", pend_cnt, 15);

        // Pulse and accept together at saturation
        tog();
        tick(3);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("t4_cnt15_hold", pend_cnt, 15);
        chk("t4_ovf_hold", ovf, 0);

        // Drain to 3, then pulse and accept together
        evt_ready = 1'b1;
        tick(12);
        evt_ready = 1'b0;
        chk("t4_cnt3", pend_cnt, 3);
        tog();
        tick(3);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("t4_cnt3_hold", pend_cnt, 3);

        // Build to 7 with tgl_in high, then reset mid-stream
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("t5_cnt2", pend_cnt, 2);
        for (int i = 0; i < 5; i++) begin
            tog();
            tick(4);
        end
        chk("t5_cnt7", pend_cnt, 7);
        chk("t5_tgl_high", tgl_in, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_cnt", pend_cnt, 0);
        chk("t5_async_valid", evt_valid, 0);
        chk("t5_async_pulse", evt_pulse, 0);
        chk("t5_async_ovf", ovf, 0);
        chk("t5_async_ack", ack_out, 0);
        tick(3);
        reset = 1'b0;
        exp_q.push_back(cyc + 1 + SYNC);
        tick(3);
        chk("t5_ack_after", ack_out, ACK ? 1 : 0);
        tick(1);
        chk("t5_cnt1", pend_cnt, 1);
        chk("t5_valid1", evt_valid, 1);
        tick(4);
        chk("t5_cnt1_stable", pend_cnt, 1);

        // Toggle back to 0: echo follows
        evt_ready = 1'b1;
        tog();
        tick(3);
        chk("t6_ack_fall", ack_out, 0);
        tick(2);
        chk("t6_cnt0", pend_cnt, 0);

        // Wait, bounded, for outstanding pulses
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
